// File: rtl/fm_synth_pkg.sv
// Shared synth definitions: I2S channel encoding, DAC word width, receiver FSM states.
package fm_synth_pkg;

  localparam logic I2S_LEFT     = 1'b0;
  localparam logic I2S_RIGHT    = 1'b1;
  localparam int   NUM_BITS_DAC = 24;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : fm_synth_pkg

// File: rtl/i2s_receiver_if.sv
// I2S receive bundle: raw async I2S pins in, parallel word stream out.
// The master side is the receiver; the slave side is the I2S source / word consumer.
interface i2s_receiver_if
  import fm_synth_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DAC
);

  logic                s_clk;
  logic                word_select;
  logic                serial_data;
  logic [NUM_BITS-1:0] word_out;
  logic                word_chan;
  logic                word_valid;
  logic                frame_err;
  logic                locked;

  modport master (
    input  s_clk, word_select, serial_data,
    output word_out, word_chan, word_valid, frame_err, locked
  );

  modport slave (
    output s_clk, word_select, serial_data,
    input  word_out, word_chan, word_valid, frame_err, locked
  );

endinterface : i2s_receiver_if

// File: rtl/i2s_rx_sync.sv
// Input synchroniser for the three async I2S pins plus the SCK rising-edge detector.
// rise, ws_s and sd_s are registered together so WS/SD are the values present at the SCK edge.
module i2s_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic s_clk,
  input  logic word_select,
  input  logic serial_data,
  output logic rise,
  output logic ws_s,
  output logic sd_s
);

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ws_sync_q,  ws_sync_d;
  logic [SYNC_STAGES-1:0] sd_sync_q,  sd_sync_d;
  logic                   s_clk_d_q,  s_clk_d_d;
  logic                   rise_q,     rise_d;
  logic                   ws_q,       ws_d;
  logic                   sd_q,       sd_d;

  // Shift each pin one stage along its synchroniser chain and detect the SCK rise.
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], s_clk};
    ws_sync_d  = {ws_sync_q[SYNC_STAGES-2:0],  word_select};
    sd_sync_d  = {sd_sync_q[SYNC_STAGES-2:0],  serial_data};
    s_clk_d_d  = sck_sync_q[SYNC_STAGES-1];
    rise_d     = sck_sync_q[SYNC_STAGES-1] & ~s_clk_d_q;
    ws_d       = ws_sync_q[SYNC_STAGES-1];
    sd_d       = sd_sync_q[SYNC_STAGES-1];
  end

  // Synchroniser and edge-detect registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q <= '0;
      ws_sync_q  <= '0;
      sd_sync_q  <= '0;
      s_clk_d_q  <= 1'b0;
      rise_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
    end else begin
      sck_sync_q <= sck_sync_d;
      ws_sync_q  <= ws_sync_d;
      sd_sync_q  <= sd_sync_d;
      s_clk_d_q  <= s_clk_d_d;
      rise_q     <= rise_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
    end
  end

  assign rise = rise_q;
  assign ws_s = ws_q;
  assign sd_s = sd_q;

endmodule : i2s_rx_sync

// File: rtl/i2s_receiver.sv
// I2S receiver: oversamples an async I2S stream and delivers one MSB-aligned word per slot.
// A WS change marks the LSB of the slot that is ending; short slots are zero-padded,
// long slots are truncated, and both are flagged with frame_err.
module i2s_receiver
  import fm_synth_pkg::*;
#(
  parameter int NUM_BITS    = NUM_BITS_DAC,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_BITS    = 6
) (
  input  logic           clk,
  input  logic           rst,
  i2s_receiver_if.master bus
);

  localparam logic [CNT_BITS-1:0] NB_CNT  = CNT_BITS'(NUM_BITS);
  localparam logic [CNT_BITS-1:0] CNT_MAX = {CNT_BITS{1'b1}};

  logic rise, ws_s, sd_s;

  i2s_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .s_clk       (bus.s_clk),
    .word_select (bus.word_select),
    .serial_data (bus.serial_data),
    .rise        (rise),
    .ws_s        (ws_s),
    .sd_s        (sd_s)
  );

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] shift_q, shift_d;
  logic [CNT_BITS-1:0] bit_cnt_q, bit_cnt_d;
  logic                ws_prev_q, ws_prev_d;
  logic [NUM_BITS-1:0] word_q, word_d;
  logic                chan_q, chan_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic                locked_q, locked_d;

  logic [CNT_BITS-1:0] n_bits;
  logic [CNT_BITS-1:0] pad_shamt;
  logic [NUM_BITS-1:0] shift_next;
  logic                slot_end;

  // Count and capture the bit arriving on this rise; a slot ends on a rise with a WS change.
  always_comb begin
    n_bits     = (bit_cnt_q == CNT_MAX) ? CNT_MAX : bit_cnt_q + CNT_BITS'(1);
    pad_shamt  = NB_CNT - n_bits;
    shift_next = (bit_cnt_q < NB_CNT) ? {shift_q[NUM_BITS-2:0], sd_s} : shift_q;
    slot_end   = rise & (ws_s != ws_prev_q);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: the first slot end after reset only aligns us; from then on we run.
  always_comb begin
    state_d = state_q;
    if (slot_end && state_q == IDLE) state_d = RUN;
  end

  // FSM outputs and datapath: shift in bits, and in RUN emit the finished word at each slot end.
  // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    ws_prev_d = ws_prev_q;
    word_d    = word_q;
    chan_d    = chan_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    if (rise) begin
      shift_d   = shift_next;
      bit_cnt_d = n_bits;
      ws_prev_d = ws_s;
      if (slot_end) begin
        shift_d   = '0;
        bit_cnt_d = '0;
        if (state_q == RUN) begin
          word_d   = (n_bits >= NB_CNT) ? shift_next : (shift_next << pad_shamt);
          chan_d   = ws_prev_q;
          err_d    = (n_bits != NB_CNT);
          valid_d  = 1'b1;
          locked_d = 1'b1;
        end
      end
    end
  end

  // Datapath and output registers.
  // NOTE: the shift register is reset too so a word cut short by rst can never leak into the next slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      ws_prev_q <= I2S_LEFT;
      word_q    <= '0;
      chan_q    <= I2S_LEFT;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      ws_prev_q <= ws_prev_d;
      word_q    <= word_d;
      chan_q    <= chan_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      locked_q  <= locked_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_chan  = chan_q;
  assign bus.word_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.locked     = locked_q;

endmodule : i2s_receiver

// File: tb/tb_i2s_receiver.sv
// Bench for i2s_receiver: behavioural I2S source at SCK = clk/8 pushes expected words into a
// scoreboard queue; a monitor pops and compares on every word_valid.
module tb_i2s_receiver;

  localparam int NB = 24;

  typedef struct {
    logic [NB-1:0] word;
    logic          chan;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2s_receiver_if #(.NUM_BITS(NB)) bus ();

  i2s_receiver #(
    .NUM_BITS    (NB),
    .SYNC_STAGES (2),
    .CNT_BITS    (6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t exp_q[$];
  int   checks    = 0;
  int   errors    = 0;
  int   valid_cnt = 0;
  logic cur_chan  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_word"},   32'(bus.word_out),   32'h0);
    check({tag, "_chan"},   32'(bus.word_chan),  32'h0);
    check({tag, "_valid"},  32'(bus.word_valid), 32'h0);
    check({tag, "_err"},    32'(bus.frame_err),  32'h0);
    check({tag, "_locked"}, 32'(bus.locked),     32'h0);
  endtask

  // One SCK period: data/WS change while SCK is low, receiver samples on the rising edge.
  task automatic send_bit(input logic ws, input logic sd);
    bus.word_select = ws;
    bus.serial_data = sd;
    #40 bus.s_clk = 1'b1;
    #40 bus.s_clk = 1'b0;
  endtask

  // One slot of len bits, MSB first, on channel cur_chan. The LSB goes out with WS already
  // toggled. When push is set the expected word is queued; rst_at >= 0 pulses rst during that bit.
  task automatic send_slot(input logic [31:0] data, input int len, input bit push, input int rst_at);
    logic   ch;
    exp_t   e;
    logic [31:0] tmp;
    ch = cur_chan;
    if (push) begin
      if (len >= NB) tmp = data >> (len - NB);
      else           tmp = (data & ((32'h1 << len) - 32'h1)) << (NB - len);
      e.word = tmp[NB-1:0];
      e.chan = ch;
      e.err  = (len != NB);
      exp_q.push_back(e);
    end
    for (int i = len - 1; i >= 0; i--) begin
      if ((len - 1 - i) == rst_at) begin
        bus.word_select = (i == 0) ? ~ch : ch;
        bus.serial_data = data[i];
        #10 rst = 1'b1;
        #1 check_all_zero("rst_mid");
        #9 rst = 1'b0;
        #20 bus.s_clk = 1'b1;
        #40 bus.s_clk = 1'b0;
      end else begin
        send_bit((i == 0) ? ~ch : ch, data[i]);
      end
    end
    cur_chan = ~ch;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (bus.word_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got word=%h chan=%0d err=%0d expected no valid (t=%0t)",
                 bus.word_out, bus.word_chan, bus.frame_err, $time);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("word_out",  32'(bus.word_out),  32'(e.word));
        check("word_chan", 32'(bus.word_chan), 32'(e.chan));
        check("frame_err", 32'(bus.frame_err), 32'(e.err));
        check("locked_on_valid", 32'(bus.locked), 32'h1);
      end
    end
  end

  initial begin
    int base;
    bus.s_clk       = 1'b0;
    bus.word_select = 1'b0;
    bus.serial_data = 1'b0;

    // Reset state
    #23 check_all_zero("reset");
    #77 rst = 1'b0;
    #40;

    // 1. Startup: partial left tail is discarded, then R, L=A5A5A5, R=5A5A5A
    send_slot(32'hF, 4, 1'b0, -1);
    #200;
    check("startup_no_valid", 32'(valid_cnt), 32'd0);
    check("startup_unlocked", 32'(bus.locked), 32'h0);
    send_slot(32'h5A5A5A, 24, 1'b1, -1);
    send_slot(32'hA5A5A5, 24, 1'b1, -1);
    send_slot(32'h5A5A5A, 24, 1'b1, -1);
    #200;
    check("startup_locked", 32'(bus.locked), 32'h1);
    check("startup_valids", 32'(valid_cnt), 32'd3);

    // 2. Full scale: 100 frames
    base = valid_cnt;
    for (int f = 0; f < 100; f++) begin
      send_slot(32'h800000, 24, 1'b1, -1);
      send_slot(32'h7FFFFF, 24, 1'b1, -1);
    end
    #200;
    check("fullscale_valids", 32'(valid_cnt - base), 32'd200);

    // 3. Short 16-bit slots: zero-padded, frame_err
    send_slot(32'h1234, 16, 1'b1, -1);
    send_slot(32'hABCD, 16, 1'b1, -1);
    // 4. Long 32-bit slots: truncated, frame_err
    send_slot(32'hDEADBEEF, 32, 1'b1, -1);
    send_slot(32'h01234567, 32, 1'b1, -1);
    // WS toggling every bit: n=1 slots
    send_slot(32'h1, 1, 1'b1, -1);
    send_slot(32'h0, 1, 1'b1, -1);
    send_slot(32'h1, 1, 1'b1, -1);
    send_slot(32'h1, 1, 1'b1, -1);
    #200;

    // SCK stopped: no spurious valid
    base = valid_cnt;
    #2000;
    check("sck_stop_no_valid", 32'(valid_cnt - base), 32'd0);

    // 5. rst at bit 10 of a left slot: that slot end is discarded, the next decodes
    check("pre_rst_chan_left", 32'(cur_chan), 32'h0);
    send_slot(32'h55AA33, 24, 1'b0, 10);
    #200;
    check("post_rst_unlocked", 32'(bus.locked), 32'h0);
    send_slot(32'h0F0F0F, 24, 1'b1, -1);
    send_slot(32'h123456, 24, 1'b1, -1);
    #400;
    check("post_rst_locked", 32'(bus.locked), 32'h1);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_i2s_receiver
